// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a single-cycle CDB broadcast tagged by ROB index.
module mul_div_unit #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     issue_valid,
    input  logic [2:0]               issue_op,
    input  logic [XLEN-1:0]          issue_rs1_data,
    input  logic [XLEN-1:0]          issue_rs2_data,
    input  logic [4:0]               issue_rd_addr,
    input  logic [ROB_IDX_WIDTH-1:0] issue_rob_idx,
    output logic                     available,
    output logic                     cdb_mul_valid,
    output logic [XLEN-1:0]          cdb_mul_data,
    output logic [4:0]               cdb_mul_rd_addr,
    output logic [ROB_IDX_WIDTH-1:0] cdb_mul_rob_idx
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    state_e                   state_q, state_d;
    op_e                      op_q;
    logic [XLEN-1:0]          a_q, b_q;
    logic [4:0]               rd_q;
    logic [ROB_IDX_WIDTH-1:0] rob_q;
    logic [CNT_W-1:0]         cnt_q;
    logic [ACC_W-1:0]         acc_q;
    logic [XLEN-1:0]          rem_q;
    logic [XLEN-1:0]          opnd_q;
    logic                     neg_q;
    logic                     neg_rem_q;

    logic                     accept_c;
    logic                     is_div_c;
    logic                     a_sgn_c, b_sgn_c, a_neg_c, b_neg_c;
    logic [XLEN-1:0]          mag_a_c, mag_b_c;
    logic [XLEN:0]            mul_sum_c;
    logic [ACC_W-1:0]         mul_step_c;
    logic [XLEN:0]            div_shift_c, div_trial_c;
    logic                     q_bit_c;
    logic [XLEN-1:0]          rem_step_c;
    logic [ACC_W-1:0]         div_acc_c;
    logic [ACC_W-1:0]         prod_c;
    logic [XLEN-1:0]          quot_c, rem_c;
    logic                     div0_c, ovf_c;
    logic [XLEN-1:0]          result_c;

    assign available     = (state_q == IDLE) || (state_q == DONE);
    assign cdb_mul_valid = (state_q == DONE) && !flush;
    assign accept_c      = available && issue_valid && !flush;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; flush overrides everything including a new accept
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = PREP;
            PREP:    state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = accept_c ? PREP : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Operand signedness, magnitudes and one iteration of each algorithm
    always_comb begin
        is_div_c = op_q[2];
        a_sgn_c  = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU)
                || (op_q == OP_DIV) || (op_q == OP_REM);
        b_sgn_c  = (op_q == OP_MUL) || (op_q == OP_MULH)
                || (op_q == OP_DIV) || (op_q == OP_REM);
        a_neg_c  = a_sgn_c && a_q[XLEN-1];
        b_neg_c  = b_sgn_c && b_q[XLEN-1];
        mag_a_c  = a_neg_c ? -a_q : a_q;
        mag_b_c  = b_neg_c ? -b_q : b_q;

        // Multiply: low half holds the remaining multiplier bits
        mul_sum_c  = {1'b0, acc_q[ACC_W-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};

        // Divide: low half shifts dividend out and quotient bits in
        div_shift_c = {rem_q, acc_q[XLEN-1]};
        div_trial_c = div_shift_c - {1'b0, opnd_q};
        q_bit_c     = !div_trial_c[XLEN];
        rem_step_c  = q_bit_c ? div_trial_c[XLEN-1:0] : div_shift_c[XLEN-1:0];
        div_acc_c   = {acc_q[ACC_W-1:XLEN], acc_q[XLEN-2:0], q_bit_c};
    end

    // Final result from the last iteration, with sign correction and special cases
    always_comb begin
        prod_c = neg_q ? -mul_step_c : mul_step_c;
        quot_c = neg_q ? -div_acc_c[XLEN-1:0] : div_acc_c[XLEN-1:0];
        rem_c  = neg_rem_q ? -rem_step_c : rem_step_c;
        div0_c = (b_q == '0);
        ovf_c  = ((op_q == OP_DIV) || (op_q == OP_REM)) && (a_q == INT_MIN) && (b_q == '1);
        case (op_q)
            OP_MUL:                   result_c = prod_c[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                 result_c = prod_c[ACC_W-1:XLEN];
            OP_DIV, OP_DIVU:          result_c = div0_c ? '1 : (ovf_c ? INT_MIN : quot_c);
            default:                  result_c = div0_c ? a_q : (ovf_c ? '0 : rem_c);
        endcase
    end

    // Operand latch, iteration datapath and broadcast payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= OP_MUL;
            a_q             <= '0;
            b_q             <= '0;
            rd_q            <= '0;
            rob_q           <= '0;
            cnt_q           <= '0;
            acc_q           <= '0;
            rem_q           <= '0;
            opnd_q          <= '0;
            neg_q           <= 1'b0;
            neg_rem_q       <= 1'b0;
            cdb_mul_data    <= '0;
            cdb_mul_rd_addr <= '0;
            cdb_mul_rob_idx <= '0;
        end else begin
            if (accept_c) begin
                op_q  <= op_e'(issue_op);
                a_q   <= issue_rs1_data;
                b_q   <= issue_rs2_data;
                rd_q  <= issue_rd_addr;
                rob_q <= issue_rob_idx;
            end
            if (state_q == PREP) begin
                acc_q     <= {{XLEN{1'b0}}, (is_div_c ? mag_a_c : mag_b_c)};
                opnd_q    <= is_div_c ? mag_b_c : mag_a_c;
                rem_q     <= '0;
                cnt_q     <= '0;
                neg_q     <= a_neg_c ^ b_neg_c;
                neg_rem_q <= a_neg_c;
            end
            if (state_q == RUN) begin
                acc_q <= is_div_c ? div_acc_c : mul_step_c;
                if (is_div_c) rem_q <= rem_step_c;
                cnt_q <= cnt_q + CNT_W'(1);
                if ((cnt_q == CNT_LAST) && !flush) begin
                    cdb_mul_data    <= result_c;
                    cdb_mul_rd_addr <= rd_q;
                    cdb_mul_rob_idx <= rob_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit.
module tb_mul_div_unit;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [31:0] issue_rs1_data, issue_rs2_data;
    logic [4:0]  issue_rd_addr;
    logic [4:0]  issue_rob_idx;
    logic        available;
    logic        cdb_mul_valid;
    logic [31:0] cdb_mul_data;
    logic [4:0]  cdb_mul_rd_addr;
    logic [4:0]  cdb_mul_rob_idx;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(32), .ROB_IDX_WIDTH(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .issue_valid     (issue_valid),
        .issue_op        (issue_op),
        .issue_rs1_data  (issue_rs1_data),
        .issue_rs2_data  (issue_rs2_data),
        .issue_rd_addr   (issue_rd_addr),
        .issue_rob_idx   (issue_rob_idx),
        .available       (available),
        .cdb_mul_valid   (cdb_mul_valid),
        .cdb_mul_data    (cdb_mul_data),
        .cdb_mul_rd_addr (cdb_mul_rd_addr),
        .cdb_mul_rob_idx (cdb_mul_rob_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op (called 1 time unit after an edge, unit available) and
    // wait for its broadcast; returns edges from accept to broadcast.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [4:0] rob,
                          output int lat, output logic [31:0] data,
                          output logic [4:0] rd_o, output logic [4:0] rob_o,
                          output bit busy_ok);
        issue_valid    = 1'b1;
        issue_op       = op;
        issue_rs1_data = a;
        issue_rs2_data = b;
        issue_rd_addr  = rd;
        issue_rob_idx  = rob;
        tick();
        issue_valid = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        data    = 'x;
        rd_o    = 'x;
        rob_o   = 'x;
        for (int i = 0; i < 40; i++) begin
            if (available !== 1'b0) busy_ok = 1'b0;
            tick();
            lat++;
            if (cdb_mul_valid === 1'b1) begin
                data  = cdb_mul_data;
                rd_o  = cdb_mul_rd_addr;
                rob_o = cdb_mul_rob_idx;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
        issue_rs1_data = '0; issue_rs2_data = '0; issue_rd_addr = '0; issue_rob_idx = '0;
        tick();
        tick();
        checks++;
        if ({available, cdb_mul_valid} !== 2'b10) begin
            errors++; $display("FAIL reset_ctrl: avail/valid=%b expected 10", {available, cdb_mul_valid});
        end
        checks++;
        if ({cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx} !== 42'd0) begin
            errors++; $display("FAIL reset_data: data=%h rd=%0d rob=%0d expected zeros",
                               cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mul();
        int lat; logic [31:0] d; logic [4:0] rd, rob; bit busy;
        run_op(MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 5'd9, lat, d, rd, rob, busy);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d expected 33", lat); end
        checks++;
        if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data: got %h expected ffffffeb", d); end
        checks++;
        if (rob !== 5'd9 || rd !== 5'd5) begin
            errors++; $display("FAIL mul_tags: rob=%0d rd=%0d expected 9/5", rob, rd);
        end
        checks++;
        if (!busy) begin errors++; $display("FAIL mul_busy: available high before DONE, expected low"); end
        tick();
        checks++;
        if (cdb_mul_valid !== 1'b0 || available !== 1'b1) begin
            errors++; $display("FAIL mul_pulse: valid=%b avail=%b expected 0/1", cdb_mul_valid, available);
        end
    endtask

    task automatic test_mulh();
        int lat; logic [31:0] d; logic [4:0] rd, rob; bit busy;
        logic [2:0]  ops [3] = '{MULH, MULHU, MULHSU};
        logic [31:0] exp [3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 5'(i), lat, d, rd, rob, busy);
            checks++;
            if (d !== exp[i] || lat !== 33) begin
                errors++; $display("FAIL mulh_%0d: data=%h lat=%0d expected %h/33", i, d, lat, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_div();
        int lat; logic [31:0] d; logic [4:0] rd, rob; bit busy;
        logic [2:0]  ops [4] = '{DIV, REM, DIVU, REMU};
        logic [31:0] as  [4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
        logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd3, 32'd2};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], 32'd6, 5'd2, 5'd3, lat, d, rd, rob, busy);
            checks++;
            if (d !== exp[i] || lat !== 33) begin
                errors++; $display("FAIL div_%0d: data=%h lat=%0d expected %h/33", i, d, lat, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_edge();
        int lat; logic [31:0] d; logic [4:0] rd, rob; bit busy;
        logic [2:0]  ops [4] = '{DIV, REM, DIV, REM};
        logic [31:0] as  [4] = '{32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd4, 5'd7, lat, d, rd, rob, busy);
            checks++;
            if (d !== exp[i] || lat !== 33) begin
                errors++; $display("FAIL edge_%0d: data=%h lat=%0d expected %h/33", i, d, lat, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat; int n; logic [31:0] d; logic [4:0] rd, rob; bit busy;
        run_op(DIVU, 32'd20, 32'd6, 5'd8, 5'd10, lat, d, rd, rob, busy);
        // Second issue presented during the DONE cycle of the first
        issue_valid = 1'b1; issue_op = MUL; issue_rs1_data = 32'd3; issue_rs2_data = 32'd5;
        issue_rd_addr = 5'd11; issue_rob_idx = 5'd12;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (available !== 1'b0) begin errors++; $display("FAIL b2b_accept: available=%b expected 0", available); end
        n = 1;
        while (cdb_mul_valid !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (n !== 34) begin errors++; $display("FAIL b2b_spacing: got %0d cycles expected 34", n); end
        checks++;
        if (cdb_mul_data !== 32'd15 || cdb_mul_rob_idx !== 5'd12 || cdb_mul_rd_addr !== 5'd11) begin
            errors++; $display("FAIL b2b_data: data=%h rob=%0d rd=%0d expected 0000000f/12/11",
                               cdb_mul_data, cdb_mul_rob_idx, cdb_mul_rd_addr);
        end
        tick();
    endtask

    task automatic test_flush();
        bit seen;
        // Flush with the iteration counter at 10
        issue_valid = 1'b1; issue_op = MUL; issue_rs1_data = 32'd9; issue_rs2_data = 32'd9;
        issue_rd_addr = 5'd1; issue_rob_idx = 5'd2;
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 11; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (available !== 1'b1 || cdb_mul_valid !== 1'b0) begin
            errors++; $display("FAIL flush_run: avail=%b valid=%b expected 1/0", available, cdb_mul_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin tick(); if (cdb_mul_valid) seen = 1'b1; end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_run_bcast: got broadcast expected none"); end

        // Flush coincident with DONE
        issue_valid = 1'b1; issue_op = MUL; issue_rs1_data = 32'd2; issue_rs2_data = 32'd2;
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 33; i++) tick();
        flush = 1'b1;
        #1;
        checks++;
        if (cdb_mul_valid !== 1'b0) begin errors++; $display("FAIL flush_done: valid=%b expected 0", cdb_mul_valid); end
        tick();
        flush = 1'b0;
        checks++;
        if (available !== 1'b1 || cdb_mul_valid !== 1'b0) begin
            errors++; $display("FAIL flush_done_after: avail=%b valid=%b expected 1/0", available, cdb_mul_valid);
        end
    endtask

    task automatic test_async_reset();
        int lat; logic [31:0] d; logic [4:0] rd, rob; bit busy;
        issue_valid = 1'b1; issue_op = MUL; issue_rs1_data = 32'd6; issue_rs2_data = 32'd7;
        issue_rd_addr = 5'd3; issue_rob_idx = 5'd4;
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (available !== 1'b1 || cdb_mul_valid !== 1'b0) begin
            errors++; $display("FAIL async_rst_ctrl: avail=%b valid=%b expected 1/0", available, cdb_mul_valid);
        end
        checks++;
        if (cdb_mul_data !== 32'd0 || cdb_mul_rd_addr !== 5'd0 || cdb_mul_rob_idx !== 5'd0) begin
            errors++; $display("FAIL async_rst_data: data=%h rd=%0d rob=%0d expected zeros",
                               cdb_mul_data, cdb_mul_rd_addr, cdb_mul_rob_idx);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(MUL, 32'd3, 32'd4, 5'd6, 5'd13, lat, d, rd, rob, busy);
        checks++;
        if (d !== 32'd12 || lat !== 33 || rob !== 5'd13 || rd !== 5'd6) begin
            errors++; $display("FAIL async_rst_after: data=%h lat=%0d rob=%0d rd=%0d expected 0000000c/33/13/6",
                               d, lat, rob, rd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_edge();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
